// File: rtl/gol_readout.sv
// Snapshot-and-stream reader for the Game of Life grid: captures all cells and
// emits one row per beat, tagged with the generation number.
// The GOL_READOUT_POPCOUNT_EN macro adds the out_pop and total_pop outputs.
module gol_readout #(
  parameter int ROWS  = 10,
  parameter int COLS  = 10,
  parameter int GEN_W = 16,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int PW = $clog2(COLS + 1),
  localparam int TW = $clog2(ROWS * COLS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] cells,
  input  logic                 gen_tick,
  input  logic                 snap_req,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [COLS-1:0]      out_data,
  output logic [RW-1:0]        out_row,
  output logic                 out_last,
  output logic [GEN_W-1:0]     out_gen,
  output logic                 busy,
`ifdef GOL_READOUT_POPCOUNT_EN
  output logic                 overrun,
  output logic [PW-1:0]        out_pop,
  output logic [TW-1:0]        total_pop
`else
  output logic                 overrun
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_nxt;
  logic [ROWS-1:0][COLS-1:0] shadow;
  logic [RW-1:0]            row;
  logic [GEN_W-1:0]         gen_count;
  logic                     hs, at_last;
  logic                     capture, advance, drop;

  assign out_valid = (state == SEND);
  assign busy      = out_valid;
  assign at_last   = (row == RW'(ROWS - 1));
  assign out_last  = out_valid && at_last;
  assign out_row   = row;
  assign out_data  = shadow[row];
  assign hs        = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs && at_last) begin
          // a request landing on the final handshake restarts with no bubble
          if (snap_req) capture   = 1'b1;
          else          state_nxt = IDLE;
        end else begin
          advance = hs;
          drop    = snap_req;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      row       <= '0;
      gen_count <= '0;
      out_gen   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (gen_tick) gen_count <= gen_count + 1'b1;
      if (capture) begin
        shadow  <= cells;
        out_gen <= gen_count;
        row     <= '0;
        overrun <= 1'b0;
      end else if (advance) begin
        row <= row + 1'b1;
      end
      if (drop) overrun <= 1'b1;
    end
  end

`ifdef GOL_READOUT_POPCOUNT_EN
  always_comb begin
    out_pop = '0;
    for (int unsigned i = 0; i < COLS; i++) out_pop = out_pop + PW'(out_data[i]);
  end

  always_ff @(posedge clk) begin
    if (rst)          total_pop <= '0;
    else if (capture) total_pop <= '0;
    else if (hs)      total_pop <= total_pop + TW'(out_pop);
  end
`endif

endmodule

// File: doc/gol_readout.md
# gol_readout

Snapshot-and-stream reader for the Game of Life cell array. It captures the full `ROWS*COLS` cell vector on request and streams it out one row per beat over a valid/ready interface, tagged with the generation number. It sits on the read side of the `gol` grid, which consumes a parallel pattern and evolves it, and feeds display, debug or host-capture logic.

## Interface

**Parameters**
- `ROWS`, default 10: grid rows.
- `COLS`, default 10: grid columns (one output beat is `COLS` bits wide).
- `GEN_W`, default 16: generation counter width.

**Ports**
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `cells` input `ROWS*COLS`: live grid state; cell (r,c) is bit `r*COLS+c`.
- `gen_tick` input 1: pulses for one cycle per grid generation step.
- `snap_req` input 1: request a snapshot; single-cycle pulse or level.
- `out_valid` output 1: beat available.
- `out_ready` input 1: consumer accepts beat.
- `out_data` output `COLS`: row data; bit c = column c.
- `out_row` output `$clog2(ROWS)`: index of the row in `out_data`.
- `out_last` output 1: high on the beat with `out_row == ROWS-1`.
- `out_gen` output `GEN_W`: generation number of the snapshot being streamed.
- `busy` output 1: snapshot held and not fully streamed.
- `overrun` output 1: sticky; a `snap_req` was dropped while busy.

## Operation

- **Generation counter `gen_count`:** increments on each `gen_tick` and wraps modulo 2^GEN_W.
- **State `IDLE`:**
  - `out_valid` = 0.
  - If `snap_req` is high, latch `cells` into the shadow register, latch `gen_count` into `out_gen`, set `out_row` = 0, clear `overrun`, and go to `SEND`.
- **State `SEND`:**
  - `out_valid` = 1.
  - `out_data` = `shadow[out_row*COLS +: COLS]`.
  - A handshake is `out_valid & out_ready`. On a handshake with `out_row < ROWS-1`, increment `out_row`.
  - On a handshake with `out_last`:
    - If `snap_req` is high in the same cycle, take a new snapshot and stay in `SEND` with `out_row` = 0 (zero-bubble restart).
    - Otherwise go to `IDLE`.
  - `snap_req` in any other `SEND` cycle is dropped and sets `overrun`.
- **Output stability:** while `out_valid` is high and `out_ready` is low, `out_data`, `out_row`, `out_last` and `out_gen` hold stable. Changes to `cells` never affect an in-flight snapshot.
- **Same-cycle `gen_tick` and snapshot:** `out_gen` captures the pre-increment `gen_count` value.
- **`busy`** = (state == `SEND`).

## Timing

- **Reset values:** state `IDLE`; `out_valid`, `out_data`, `out_row`, `out_last`, `out_gen`, `busy`, `overrun` and `gen_count` are all 0. The shadow register is cleared.
- **Latency:** `snap_req` sampled at edge N gives `out_valid` = 1 with row 0 from cycle N+1.
- **Stream length:** `ROWS` beats minimum, with `out_ready` held high.
- **Throughput:** one row per cycle. Continuous back-to-back snapshots need `snap_req` to coincide with the last handshake.
- **Reset mid-stream:** `rst` in `SEND` aborts the stream. `out_valid` is 0 in the next cycle and the partial snapshot is discarded.
- **Outputs:** all outputs are registered or decoded from registered state only; there is no combinational path from `out_ready` or `snap_req` to outputs.

## Configuration

- **Macro:** `GOL_READOUT_POPCOUNT_EN`.
- **When defined,** two extra output ports exist:
  - `out_pop`, width `$clog2(COLS+1)`: number of live cells in the current `out_data`.
  - `total_pop`, width `$clog2(ROWS*COLS+1)`: running sum of `out_pop` over handshaked beats of the current snapshot.
- **`total_pop` behaviour:**
  - Reset to 0 on snapshot capture.
  - Valid for the full grid in the cycle after the `out_last` handshake.
  - Holds until the next capture.
  - Reset value of both ports is 0.
- **When undefined,** neither port exists and no popcount logic is built.

## Test plan

- **Reset behaviour:** assert `rst` 2 cycles with `snap_req` = 1 → all outputs 0 during reset. `snap_req` = 1 in the first post-reset cycle → `out_valid` = 1, `out_row` = 0 next cycle.
- **Glider stream:** load a glider in rows 1–3 and snapshot with `out_ready` = 1 → 10 beats in consecutive cycles, rows 0..9, correct bit patterns, `out_last` only on row 9. With popcount enabled, `total_pop` = 5.
- **Backpressure:** randomly toggle `out_ready` and change `cells` every cycle → data equals the captured grid, and `out_*` is stable on every stalled cycle.
- **Overrun and generation tag:** three `gen_tick`s, snapshot, then `snap_req` at row 4 → `out_gen` = 3, `overrun` = 1 until the next accepted snapshot, and the stream is unaffected.
- **Back-to-back restart:** `snap_req` coincident with the row-9 handshake → row 0 of the new snapshot the next cycle with no `out_valid` gap, and `out_gen` updated.
- **Counter wrap and mid-stream reset:** `GEN_W` = 4 with 17 `gen_tick`s, then snapshot → `out_gen` = 1. `rst` at row 5 → `out_valid` = 0 and `busy` = 0 in the next cycle.
